// File: rtl/data_memory_sequencer.sv
// data_memory_sequencer
// Initiator side of the data-memory address/data interface. It turns one CPU
// load/store burst request (1..16 beats) into the sequence of cycles the memory
// manager expects: load the address register, then either a write-enable pulse
// or a read-enable window. The address increments automatically between beats.
// IO port addresses are treated like any other address.
//
// Ports:
//   clk, in_reset            clock (rising edge), synchronous active-high reset
//   in_req/in_we/in_addr/in_len  burst request, sampled only while idle
//   in_wdata/in_wdata_valid  store data stream; out_wdata_ready accepts a beat
//   out_rdata/out_rdata_valid    load data stream (one-cycle valid pulse per beat)
//   out_busy/out_done/out_wrapped  burst status
//   out_mem_*                address/enables/store data to the memory manager
//   in_mem_data              read data from the memory manager
module data_memory_sequencer #(
  parameter int unsigned READ_WAIT = 0
) (
  input  logic       clk,
  input  logic       in_reset,
  input  logic       in_req,
  input  logic       in_we,
  input  logic [9:0] in_addr,
  input  logic [3:0] in_len,
  input  logic [7:0] in_wdata,
  input  logic       in_wdata_valid,
  output logic       out_wdata_ready,
  output logic [7:0] out_rdata,
  output logic       out_rdata_valid,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_wrapped,
  output logic [9:0] out_mem_addr,
  output logic       out_mem_addr_write_en,
  output logic       out_mem_read_en,
  output logic       out_mem_write_en,
  output logic [7:0] out_mem_data,
  input  logic [7:0] in_mem_data
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_ADDR  = 3'd1,
    S_WAIT_WDATA = 3'd2,
    S_WRITE      = 3'd3,
    S_READ       = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  // Index of the last read-enable cycle of a beat.
  localparam logic [1:0] READ_LAST = 2'(READ_WAIT);

  state_t     state_r;
  state_t     state_s;
  logic       we_r;
  logic [9:0] cur_addr_r;
  logic [3:0] beats_left_r;
  logic [1:0] wait_cnt_r;
  logic [7:0] mem_data_r;
  logic [7:0] rdata_r;
  logic       rdata_valid_r;
  logic       wrapped_r;
  logic       read_last_s;
  logic       beat_end_s;

  assign read_last_s = (wait_cnt_r == READ_LAST);
  // A beat finishes on the single WRITE cycle or the last READ cycle.
  assign beat_end_s  = (state_r == S_WRITE) || ((state_r == S_READ) && read_last_s);

  // State register.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_req) begin
          state_s = S_LOAD_ADDR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD_ADDR: begin
        if (we_r) begin
          state_s = S_WAIT_WDATA;
        end else begin
          state_s = S_READ;
        end
      end
      S_WAIT_WDATA: begin
        if (in_wdata_valid) begin
          state_s = S_WRITE;
        end else begin
          state_s = S_WAIT_WDATA;
        end
      end
      S_WRITE, S_READ: begin
        if (!beat_end_s) begin
          state_s = state_r;
        end else if (beats_left_r == 4'd0) begin
          state_s = S_DONE;
        end else begin
          state_s = S_LOAD_ADDR;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Burst datapath: captured request, address/beat counters, data latches.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      we_r          <= 1'b0;
      cur_addr_r    <= 10'd0;
      beats_left_r  <= 4'd0;
      wait_cnt_r    <= 2'd0;
      mem_data_r    <= 8'd0;
      rdata_r       <= 8'd0;
      rdata_valid_r <= 1'b0;
      wrapped_r     <= 1'b0;
    end else begin
      rdata_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (in_req) begin
            we_r         <= in_we;
            cur_addr_r   <= in_addr;
            beats_left_r <= in_len;
            wrapped_r    <= 1'b0;
          end
        end
        S_WAIT_WDATA: begin
          if (in_wdata_valid) begin
            mem_data_r <= in_wdata;
          end
        end
        S_READ: begin
          if (read_last_s) begin
            rdata_r       <= in_mem_data;
            rdata_valid_r <= 1'b1;
            wait_cnt_r    <= 2'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end
        end
        default: begin
        end
      endcase
      // Step to the next beat; the 10-bit add wraps 0x3FF -> 0x000 naturally.
      if (beat_end_s && (beats_left_r != 4'd0)) begin
        beats_left_r <= beats_left_r - 4'd1;
        cur_addr_r   <= cur_addr_r + 10'd1;
        if (cur_addr_r == 10'h3FF) begin
          wrapped_r <= 1'b1;
        end
      end
    end
  end

  // Strobes decoded from the registered state only, so the three memory
  // enables are exclusive by construction.
  always_comb begin
    out_busy              = (state_r != S_IDLE);
    out_done              = (state_r == S_DONE);
    out_wdata_ready       = (state_r == S_WAIT_WDATA);
    out_mem_addr_write_en = (state_r == S_LOAD_ADDR);
    out_mem_read_en       = (state_r == S_READ);
    out_mem_write_en      = (state_r == S_WRITE);
  end

  assign out_mem_addr    = cur_addr_r;
  assign out_mem_data    = mem_data_r;
  assign out_rdata       = rdata_r;
  assign out_rdata_valid = rdata_valid_r;
  assign out_wrapped     = wrapped_r;

endmodule

// File: tb/tb_data_memory_sequencer.sv
// Scoreboard bench for data_memory_sequencer. Instance 0 uses READ_WAIT=0,
// instance 1 uses READ_WAIT=2. Stimulus pushes expected memory-interface events
// (kind, cycle offset, address, data); a negedge monitor pops and compares.
module tb_data_memory_sequencer;

  localparam int K_ADDR = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam int K_RV   = 3;
  localparam int K_DONE = 4;

  typedef struct {
    int         kind;
    int         cyc;
    logic [9:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       req[2], we[2], wvalid[2];
  logic [9:0] addr[2];
  logic [3:0] len[2];
  logic [7:0] wdata[2];
  logic       rdy[2], rv[2], busy[2], done[2], wrap[2], aw[2], rd[2], wr[2];
  logic [7:0] rdata[2], mdata[2], mdin[2];
  logic [9:0] maddr[2];

  ev_t        q0[$];
  ev_t        q1[$];
  logic [7:0] wq[$];
  int         base[2];
  int         ncyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // Memory model: read data is a fixed function of the address presented.
  assign mdin[0] = maddr[0][7:0] ^ 8'hB5;
  assign mdin[1] = maddr[1][7:0] ^ 8'hB5;

  data_memory_sequencer #(.READ_WAIT(0)) u_dut0 (
    .clk(clk), .in_reset(rst), .in_req(req[0]), .in_we(we[0]), .in_addr(addr[0]),
    .in_len(len[0]), .in_wdata(wdata[0]), .in_wdata_valid(wvalid[0]),
    .out_wdata_ready(rdy[0]), .out_rdata(rdata[0]), .out_rdata_valid(rv[0]),
    .out_busy(busy[0]), .out_done(done[0]), .out_wrapped(wrap[0]),
    .out_mem_addr(maddr[0]), .out_mem_addr_write_en(aw[0]), .out_mem_read_en(rd[0]),
    .out_mem_write_en(wr[0]), .out_mem_data(mdata[0]), .in_mem_data(mdin[0])
  );

  data_memory_sequencer #(.READ_WAIT(2)) u_dut1 (
    .clk(clk), .in_reset(rst), .in_req(req[1]), .in_we(we[1]), .in_addr(addr[1]),
    .in_len(len[1]), .in_wdata(wdata[1]), .in_wdata_valid(wvalid[1]),
    .out_wdata_ready(rdy[1]), .out_rdata(rdata[1]), .out_rdata_valid(rv[1]),
    .out_busy(busy[1]), .out_done(done[1]), .out_wrapped(wrap[1]),
    .out_mem_addr(maddr[1]), .out_mem_addr_write_en(aw[1]), .out_mem_read_en(rd[1]),
    .out_mem_write_en(wr[1]), .out_mem_data(mdata[1]), .in_mem_data(mdin[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic push(input int d, input int k, input int off,
                      input logic [9:0] a, input logic [7:0] dt);
    ev_t e;
    e.kind = k;
    e.cyc  = base[d] + off;
    e.addr = a;
    e.data = dt;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Compare one observed event against the head of that instance's queue.
  task automatic check_ev(input int d, input int k);
    ev_t  e;
    logic bad;
    n_assert++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_event dut%0d: got kind %0d at cycle %0d, expected none", d, k, ncyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      bad = (e.kind != k) || (e.cyc != ncyc);
      if (k <= K_WR && maddr[d] !== e.addr) bad = 1'b1;
      if (k == K_WR && mdata[d] !== e.data) bad = 1'b1;
      if (k == K_RV && rdata[d] !== e.data) bad = 1'b1;
      if (bad) begin
        n_fail++;
        $display("FAIL event dut%0d: got kind %0d cyc %0d addr %0h wdata %0h rdata %0h, expected kind %0d cyc %0d addr %0h data %0h",
                 d, k, ncyc, maddr[d], mdata[d], rdata[d], e.kind, e.cyc, e.addr, e.data);
      end
    end
  endtask

  // Monitor: one sample per cycle, away from the active edge.
  always @(negedge clk) begin
    ncyc++;
    for (int d = 0; d < 2; d++) begin
      n_assert++;
      if ($countones({aw[d], rd[d], wr[d]}) > 1) begin
        n_fail++;
        $display("FAIL enable_overlap dut%0d: got aw/rd/wr %b%b%b, expected at most one", d, aw[d], rd[d], wr[d]);
      end
      for (int k = 0; k < 5; k++) begin
        logic hit;
        case (k)
          K_ADDR:  hit = aw[d];
          K_RD:    hit = rd[d];
          K_WR:    hit = wr[d];
          K_RV:    hit = rv[d];
          default: hit = done[d];
        endcase
        if (hit) check_ev(d, k);
      end
    end
  end

  // Store-data feeder for instance 0: advance to the next beat after acceptance.
  always begin
    @(negedge clk);
    if (rdy[0] && wvalid[0] && wq.size() > 0) begin
      @(posedge clk);
      #1;
      void'(wq.pop_front());
      if (wq.size() > 0) wdata[0] = wq[0];
    end
  end

  // Must be called at negedge+1; the request is sampled on the next edge.
  task automatic start(input int d, input logic w, input logic [9:0] a, input logic [3:0] l);
    req[d]  = 1'b1;
    we[d]   = w;
    addr[d] = a;
    len[d]  = l;
    base[d] = ncyc;
  endtask

  task automatic release_req(input int d);
    @(negedge clk); #1;
    req[d] = 1'b0;
  endtask

  task automatic at_off(input int d, input int off);
    while (ncyc < base[d] + off) begin
      @(negedge clk); #1;
    end
  endtask

  // Bounded wait for out_done, then step into the following idle cycle.
  task automatic wait_done(input int d, input int limit);
    int i = 0;
    while (!done[d] && i < limit) begin
      @(negedge clk); #1;
      i++;
    end
    n_assert++;
    if (!done[d]) begin
      n_fail++;
      $display("FAIL done_timeout dut%0d: got no out_done, expected within %0d cycles", d, limit);
    end
    @(negedge clk); #1;
    chk("busy_after_done", 32'(busy[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 10'd0; len[d] = 4'd0;
      wdata[d] = 8'd0; wvalid[d] = 1'b0;
    end

    // Reset held with a request pending: nothing may start.
    req[0] = 1'b1; addr[0] = 10'h010;
    repeat (3) begin @(negedge clk); #1; end
    chk("rst_busy",  32'(busy[0]), 32'd0);
    chk("rst_en",    32'({aw[0], rd[0], wr[0], rdy[0]}), 32'd0);
    chk("rst_addr",  32'(maddr[0]), 32'd0);
    chk("rst_out",   32'({rdata[0], mdata[0], rv[0], done[0], wrap[0]}), 32'd0);
    rst = 1'b0; req[0] = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_busy", 32'(busy[0]), 32'd0);
    chk("post_rst_en",   32'({aw[0], rd[0], wr[0]}), 32'd0);

    // Single load at 0x010.
    start(0, 1'b0, 10'h010, 4'd0);
    push(0, K_ADDR, 1, 10'h010, 8'h00);
    push(0, K_RD,   2, 10'h010, 8'h00);
    push(0, K_RV,   3, 10'h000, 8'hA5);
    push(0, K_DONE, 3, 10'h000, 8'h00);
    release_req(0);
    wait_done(0, 20);

    // Store burst 0x100..0x102, valid held; a request pulse mid-burst is ignored.
    wq = '{8'h11, 8'h22, 8'h33};
    wdata[0] = 8'h11; wvalid[0] = 1'b1;
    start(0, 1'b1, 10'h100, 4'd2);
    for (int k = 0; k < 3; k++) begin
      push(0, K_ADDR, 1 + 3 * k, 10'h100 + 10'(k), 8'h00);
      push(0, K_WR,   3 + 3 * k, 10'h100 + 10'(k), 8'h11 * 8'(k + 1));
    end
    push(0, K_DONE, 10, 10'h000, 8'h00);
    release_req(0);
    at_off(0, 4);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h155; len[0] = 4'd5;
    at_off(0, 5);
    req[0] = 1'b0;
    wait_done(0, 30);
    wvalid[0] = 1'b0;

    // Store with write data withheld for five WAIT_WDATA cycles.
    wq.delete();
    wdata[0] = 8'h5C;
    start(0, 1'b1, 10'h200, 4'd0);
    push(0, K_ADDR, 1, 10'h200, 8'h00);
    push(0, K_WR,   7, 10'h200, 8'h5C);
    push(0, K_DONE, 8, 10'h000, 8'h00);
    release_req(0);
    for (int off = 2; off <= 6; off++) begin
      at_off(0, off);
      chk("wait_ready", 32'(rdy[0]), 32'd1);
      chk("wait_no_we", 32'(wr[0]), 32'd0);
    end
    wvalid[0] = 1'b1;
    wait_done(0, 20);
    wvalid[0] = 1'b0;

    // Load burst across the top of the address space.
    start(0, 1'b0, 10'h3FE, 4'd2);
    for (int k = 0; k < 3; k++) begin
      push(0, K_ADDR, 1 + 2 * k, 10'h3FE + 10'(k), 8'h00);
      if (k > 0) push(0, K_RV, 1 + 2 * k, 10'h000, 8'(10'h3FE + 10'(k - 1)) ^ 8'hB5);
      push(0, K_RD, 2 + 2 * k, 10'h3FE + 10'(k), 8'h00);
    end
    push(0, K_RV,   7, 10'h000, 8'hB5);
    push(0, K_DONE, 7, 10'h000, 8'h00);
    release_req(0);
    at_off(0, 3);
    chk("wrap_before", 32'(wrap[0]), 32'd0);
    at_off(0, 5);
    chk("wrap_set", 32'(wrap[0]), 32'd1);
    wait_done(0, 20);
    chk("wrap_sticky", 32'(wrap[0]), 32'd1);

    // Store burst of four, reset while beat 2 is in WRITE.
    wq = '{8'h41, 8'h42, 8'h43, 8'h44};
    wdata[0] = 8'h41; wvalid[0] = 1'b1;
    start(0, 1'b1, 10'h080, 4'd3);
    push(0, K_ADDR, 1, 10'h080, 8'h00);
    push(0, K_WR,   3, 10'h080, 8'h41);
    push(0, K_ADDR, 4, 10'h081, 8'h00);
    push(0, K_WR,   6, 10'h081, 8'h42);
    release_req(0);
    chk("wrap_cleared", 32'(wrap[0]), 32'd0);
    at_off(0, 6);
    rst = 1'b1;
    at_off(0, 7);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_en",   32'({aw[0], rd[0], wr[0], done[0]}), 32'd0);
    rst = 1'b0; wvalid[0] = 1'b0; wq.delete();
    repeat (3) begin @(negedge clk); #1; end
    chk("idle_after_rst", 32'(busy[0]), 32'd0);
    start(0, 1'b0, 10'h155, 4'd0);
    push(0, K_ADDR, 1, 10'h155, 8'h00);
    push(0, K_RD,   2, 10'h155, 8'h00);
    push(0, K_RV,   3, 10'h000, 8'hE0);
    push(0, K_DONE, 3, 10'h000, 8'h00);
    release_req(0);
    wait_done(0, 20);

    // READ_WAIT=2 instance: read enable held three cycles.
    start(1, 1'b0, 10'h2AA, 4'd0);
    push(1, K_ADDR, 1, 10'h2AA, 8'h00);
    push(1, K_RD,   2, 10'h2AA, 8'h00);
    push(1, K_RD,   3, 10'h2AA, 8'h00);
    push(1, K_RD,   4, 10'h2AA, 8'h00);
    push(1, K_RV,   5, 10'h000, 8'h1F);
    push(1, K_DONE, 5, 10'h000, 8'h00);
    release_req(1);
    wait_done(1, 20);

    repeat (4) begin @(negedge clk); #1; end
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_sequencer.md
Name: data_memory_sequencer

Overview:
- Initiator side of the data-memory address/data interface: converts a CPU load/store burst request into the address-register-load, read-enable and write-enable cycle sequence the memory manager consumes.
- Sits between the control unit and the data memory manager.
- Handles single or burst (1..16 beats) accesses with auto-incrementing 10-bit address, a valid/ready write-data stream, and a read-data pulse stream.
- IO port addresses (0x3FE in, 0x3FF out) are ordinary addresses to this block.

Parameters:
- READ_WAIT, 0, extra cycles read_en is held before read data is sampled (0..3).

Ports:
- clk  input  1  clock, all logic on rising edge
- in_reset  input  1  synchronous, active-high reset
- in_req  input  1  start request; sampled only when out_busy=0
- in_we  input  1  1=store burst, 0=load burst; captured with in_req
- in_addr  input  10  start address; captured with in_req
- in_len  input  4  beats minus one (0 => 1 beat, 15 => 16 beats); captured with in_req
- in_wdata  input  8  store data beat
- in_wdata_valid  input  1  store data present
- out_wdata_ready  output  1  sequencer accepts in_wdata this cycle
- out_rdata  output  8  load data beat
- out_rdata_valid  output  1  one-cycle pulse, out_rdata valid
- out_busy  output  1  burst in progress (state != IDLE)
- out_done  output  1  one-cycle pulse at burst end
- out_wrapped  output  1  sticky: burst address wrapped 0x3FF->0x000; cleared on next accepted request
- out_mem_addr  output  10  address to memory manager
- out_mem_addr_write_en  output  1  load manager address register
- out_mem_read_en  output  1  memory read enable
- out_mem_write_en  output  1  memory write enable
- out_mem_data  output  8  store data to memory manager
- in_mem_data  input  8  read data from memory manager

Behaviour:
- Reset: state IDLE; all outputs 0, including out_mem_addr, out_mem_data, out_rdata, out_wrapped. Reset overrides any in-flight burst. Enables drop at the reset edge. Partial writes are not undone.
- All outputs are registered or decoded from the registered state only; no combinational in->out paths.
- States: IDLE, LOAD_ADDR, WAIT_WDATA, WRITE, READ, DONE.
- IDLE:
  - When in_req=1, capture in_we, in_addr, in_len into cur_addr and beats_left=in_len, clear out_wrapped, go to LOAD_ADDR.
  - in_req while busy is ignored; it is not queued.
- LOAD_ADDR: out_mem_addr=cur_addr, out_mem_addr_write_en=1 for exactly one cycle. Next state is WAIT_WDATA if store, READ if load.
- WAIT_WDATA:
  - out_wdata_ready=1.
  - On in_wdata_valid=1, latch in_wdata into out_mem_data and go to WRITE.
  - Otherwise stay, with no timeout.
- WRITE: out_mem_write_en=1 for one cycle with stable out_mem_data.
- READ:
  - out_mem_read_en=1 for READ_WAIT+1 cycles; a wait counter counts these cycles.
  - On the final cycle's edge, in_mem_data is latched into out_rdata.
  - out_rdata_valid=1 the following cycle, for exactly one cycle.
- Beat end (leaving WRITE or READ):
  - If beats_left=0, go to DONE.
  - Otherwise beats_left-1, cur_addr+1 modulo 1024, then LOAD_ADDR.
  - If cur_addr was 0x3FF when incremented, set out_wrapped=1.
- DONE: out_done=1 for one cycle, then IDLE. The final read's out_rdata_valid coincides with the DONE cycle.
- Enable exclusivity: out_mem_addr_write_en, out_mem_read_en and out_mem_write_en are mutually exclusive in every cycle.
- Latency, with READ_WAIT=0 and in_req sampled at edge 0:
  - Single load: addr_write_en in cycle 1, read_en in cycle 2, rdata_valid+done in cycle 3; out_busy=0 in cycle 4.
  - Single store, with wdata_valid already high: LOAD_ADDR 1, WAIT_WDATA 2, WRITE 3, DONE 4.
- A new request is accepted in the IDLE cycle immediately after DONE; there are no dead cycles beyond that.

Test Plan:
- Reset with req held high: after reset release, out_busy=0 and all mem enables 0. req at 0x010, len=0, load, in_mem_data=0xA5 -> addr_write_en cycle 1 with addr 0x010, read_en cycle 2, out_rdata=0xA5 with out_rdata_valid=out_done=1 in cycle 3.
- Store burst at 0x100, len=2, data 0x11/0x22/0x33 with valid held -> three write_en pulses at addresses 0x100/0x101/0x102 carrying matching data; one out_done; enables never overlap.
- Store with in_wdata_valid low for 5 cycles -> stays in WAIT_WDATA with out_wdata_ready=1, write_en=0; accepts on first valid cycle.
- Load burst at 0x3FE, len=2 (IO in port, IO out port, 0x000) -> addresses 0x3FE, 0x3FF, 0x000; out_wrapped=1 after the third address load; cleared by the next accepted request.
- READ_WAIT=2 build, single load -> read_en high 3 cycles, rdata_valid one cycle later.
- in_reset asserted mid-burst (store, beat 2 of 4 in WRITE) -> next cycle all enables 0, out_busy=0, no out_done; a subsequent request runs normally. Also: in_req pulsed while busy -> ignored, and the burst count is unchanged.
